// File: rtl/chip_test_sequencer.sv
// Command sequencer: pops command words from FIFO A, drives the serial master,
// waits on synchronized chip status with a timeout and returns results via FIFO B.
module chip_test_sequencer #(
  parameter int unsigned     TO_W   = 24,
  parameter logic [TO_W-1:0] TO_CYC = 24'd10_000_000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] FIFOA_OUT,
  output logic        FIFOA_ren,
  input  logic        FIFOA_empty,
  output logic [31:0] FIFOB_IN,
  output logic        FIFOB_wen,
  input  logic        FIFOB_prog_full,
  output logic        itf_sel,
  output logic        ser_req,
  output logic        ser_rd,
  output logic [15:0] ser_wdata,
  input  logic        ser_done,
  input  logic [15:0] ser_rdata,
  input  logic        sta_wei,
  input  logic        sta_act,
  output logic        busy,
  output logic        err_to,
  output logic        err_op,
  output logic [15:0] cmd_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_DFETCH, S_DLATCH, S_SREQ, S_RESP, S_WAIT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_SEL   = 4'h1,
    OP_WRITE = 4'h2,
    OP_READ  = 4'h3,
    OP_WEI   = 4'h4,
    OP_ACT   = 4'h5
  } op_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_CYC - 1'b1;

  state_t          state_q;
  op_t             op_q;
  op_t             dec_op;
  logic [11:0]     n_q;
  logic [11:0]     beat_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            ser_req_q;
  logic            ser_rd_q;
  logic [15:0]     ser_wdata_q;
  logic [31:0]     fifob_data_q;
  logic            itf_sel_q;
  logic            err_to_q;
  logic            err_op_q;
  logic [15:0]     cmd_cnt_q;
  logic            wei_meta_q, wei_sync_q;
  logic            act_meta_q, act_sync_q;
  logic            wait_cond;

  assign dec_op    = op_t'(FIFOA_OUT[31:28]);
  assign wait_cond = (op_q == OP_WEI) ? wei_sync_q : act_sync_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      n_q          <= '0;
      beat_q       <= '0;
      to_cnt_q     <= '0;
      ser_req_q    <= 1'b0;
      ser_rd_q     <= 1'b0;
      ser_wdata_q  <= '0;
      fifob_data_q <= '0;
      itf_sel_q    <= 1'b0;
      err_to_q     <= 1'b0;
      err_op_q     <= 1'b0;
      cmd_cnt_q    <= '0;
      wei_meta_q   <= 1'b0;
      wei_sync_q   <= 1'b0;
      act_meta_q   <= 1'b0;
      act_sync_q   <= 1'b0;
    end else begin
      wei_meta_q <= sta_wei;
      wei_sync_q <= wei_meta_q;
      act_meta_q <= sta_act;
      act_sync_q <= act_meta_q;

      case (state_q)
        S_IDLE:  if (!FIFOA_empty) state_q <= S_FETCH;
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          op_q     <= dec_op;
          n_q      <= FIFOA_OUT[27:16];
          beat_q   <= '0;
          to_cnt_q <= '0;
          case (dec_op)
            OP_SEL: begin
              itf_sel_q <= FIFOA_OUT[0];
              state_q   <= S_IDLE;
              cmd_cnt_q <= cmd_cnt_q + 1'b1;
            end
            OP_NOP: begin
              state_q   <= S_IDLE;
              cmd_cnt_q <= cmd_cnt_q + 1'b1;
            end
            OP_WRITE: state_q <= S_DFETCH;
            OP_READ: begin
              ser_req_q   <= 1'b1;
              ser_rd_q    <= 1'b1;
              ser_wdata_q <= FIFOA_OUT[15:0];
              state_q     <= S_SREQ;
            end
            OP_WEI, OP_ACT: state_q <= S_WAIT;
            default: begin
              err_op_q  <= 1'b1;
              state_q   <= S_IDLE;
              cmd_cnt_q <= cmd_cnt_q + 1'b1;
            end
          endcase
        end
        S_DFETCH: if (!FIFOA_empty) state_q <= S_DLATCH;
        S_DLATCH: begin
          ser_wdata_q <= FIFOA_OUT[15:0];
          ser_rd_q    <= 1'b0;
          ser_req_q   <= 1'b1;
          state_q     <= S_SREQ;
        end
        S_SREQ: if (ser_done) begin
          ser_req_q <= 1'b0;
          if (op_q == OP_READ) begin
            fifob_data_q <= {4'h3, beat_q, ser_rdata};
            state_q      <= S_RESP;
          end else if (beat_q == n_q) begin
            state_q   <= S_IDLE;
            cmd_cnt_q <= cmd_cnt_q + 1'b1;
          end else begin
            beat_q  <= beat_q + 1'b1;
            state_q <= S_DFETCH;
          end
        end
        // RESP serves both read beats and wait results; only reads loop back.
        S_RESP: if (!FIFOB_prog_full) begin
          if (op_q == OP_READ && beat_q != n_q) begin
            beat_q    <= beat_q + 1'b1;
            ser_req_q <= 1'b1;
            state_q   <= S_SREQ;
          end else begin
            state_q   <= S_IDLE;
            cmd_cnt_q <= cmd_cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cond) begin
            fifob_data_q <= {op_q, 27'd0, 1'b0};
            state_q      <= S_RESP;
          end else if (to_cnt_q == TO_LAST) begin
            err_to_q     <= 1'b1;
            fifob_data_q <= {op_q, 27'd0, 1'b1};
            state_q      <= S_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read enable and write enable are decoded combinationally so the popped word
  // lands in the following state and a write can never coincide with prog_full.
  assign FIFOA_ren = !rst && ((state_q == S_FETCH) || (state_q == S_DFETCH && !FIFOA_empty));
  assign FIFOB_wen = !rst && (state_q == S_RESP) && !FIFOB_prog_full;
  assign FIFOB_IN  = fifob_data_q;
  assign busy      = (state_q != S_IDLE);
  assign itf_sel   = itf_sel_q;
  assign ser_req   = ser_req_q;
  assign ser_rd    = ser_rd_q;
  assign ser_wdata = ser_wdata_q;
  assign err_to    = err_to_q;
  assign err_op    = err_op_q;
  assign cmd_cnt   = cmd_cnt_q;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Directed bench for chip_test_sequencer with FIFO A/B models and a serial slave.
module tb_chip_test_sequencer;

  logic        CLK = 1'b0;
  logic        rst;
  logic [31:0] FIFOA_OUT = '0;
  logic        FIFOA_ren;
  logic        FIFOA_empty;
  logic [31:0] FIFOB_IN;
  logic        FIFOB_wen;
  logic        FIFOB_prog_full;
  logic        itf_sel;
  logic        ser_req;
  logic        ser_rd;
  logic [15:0] ser_wdata;
  logic        ser_done;
  logic [15:0] ser_rdata = '0;
  logic        sta_wei;
  logic        sta_act;
  logic        busy;
  logic        err_to;
  logic        err_op;
  logic [15:0] cmd_cnt;

  chip_test_sequencer #(.TO_W(24), .TO_CYC(24'd100)) dut (
    .CLK(CLK), .rst(rst),
    .FIFOA_OUT(FIFOA_OUT), .FIFOA_ren(FIFOA_ren), .FIFOA_empty(FIFOA_empty),
    .FIFOB_IN(FIFOB_IN), .FIFOB_wen(FIFOB_wen), .FIFOB_prog_full(FIFOB_prog_full),
    .itf_sel(itf_sel), .ser_req(ser_req), .ser_rd(ser_rd), .ser_wdata(ser_wdata),
    .ser_done(ser_done), .ser_rdata(ser_rdata),
    .sta_wei(sta_wei), .sta_act(sta_act),
    .busy(busy), .err_to(err_to), .err_op(err_op), .cmd_cnt(cmd_cnt)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // FIFO A model: data appears the cycle after a read enable.
  logic [31:0] memA [0:255];
  int wa = 0;
  int ra = 0;
  assign FIFOA_empty = (wa == ra);
  always @(posedge CLK) begin
    if (FIFOA_ren && wa != ra) begin
      FIFOA_OUT <= memA[ra[7:0]];
      ra <= ra + 1;
    end
  end

  // FIFO B capture plus back-pressure violation monitor.
  logic [31:0] qb[$];
  int wen_full_viol = 0;
  always @(posedge CLK) begin
    if (FIFOB_wen) qb.push_back(FIFOB_IN);
    if (FIFOB_wen && FIFOB_prog_full) wen_full_viol++;
  end

  // Serial slave with programmable latency; logs each completed transaction.
  logic        slave_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [15:0] rdq[$];
  logic        log_rd[$];
  logic [15:0] log_wd[$];
  int sl_lat = 2;
  int sl_cnt = 0;
  int stab_err = 0;
  logic p_req = 1'b0, p_rd = 1'b0, p_itf = 1'b0;
  logic [15:0] p_wd = '0;
  assign ser_done = slave_done | stray_done;

  always @(posedge CLK) begin
    slave_done <= 1'b0;
    if (ser_req && p_req && (ser_rd != p_rd || ser_wdata != p_wd || itf_sel != p_itf)) stab_err++;
    p_req <= ser_req; p_rd <= ser_rd; p_wd <= ser_wdata; p_itf <= itf_sel;
    if (ser_req && !slave_done) begin
      if (sl_cnt >= sl_lat) begin
        slave_done <= 1'b1;
        ser_rdata  <= (rdq.size() > 0) ? rdq.pop_front() : 16'hDEAD;
        log_rd.push_back(ser_rd);
        log_wd.push_back(ser_wdata);
        sl_cnt <= 0;
      end else begin
        sl_cnt <= sl_cnt + 1;
      end
    end else if (!ser_req) begin
      sl_cnt <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic push_a(input logic [31:0] w);
    memA[wa[7:0]] = w;
    wa++;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int c = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    while ((busy || !FIFOA_empty) && c < budget) begin
      @(posedge CLK); #1;
      c++;
    end
    chk({nm, " idle"}, 32'(c < budget), 32'd1);
  endtask

  typedef struct {
    logic [31:0] cmd;
    logic        itf;
    logic        eop;
  } vec_t;

  vec_t vt [6];
  int   exp_cnt;
  int   c;

  initial begin
    vt[0] = '{32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{32'h1000_0000, 1'b0, 1'b0};
    vt[2] = '{32'h1ABC_FFFF, 1'b1, 1'b0};
    vt[3] = '{32'h9000_0000, 1'b1, 1'b1};
    vt[4] = '{32'hF123_4567, 1'b1, 1'b1};
    vt[5] = '{32'h1000_0002, 1'b0, 1'b1};

    rst = 1'b1; FIFOB_prog_full = 1'b0; sta_wei = 1'b0; sta_act = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst ser_req", ser_req, 0);
    chk("rst busy", busy, 0);
    chk("rst wen", FIFOB_wen, 0);
    chk("rst ren", FIFOA_ren, 0);
    chk("rst cmd_cnt", cmd_cnt, 0);
    chk("rst errs", {err_to, err_op, itf_sel, ser_rd}, 0);
    rst = 1'b0;

    // SEL_ITF latency
    @(negedge CLK); push_a(32'h1000_0001);
    @(negedge CLK); chk("sel ren", FIFOA_ren, 1);
    @(negedge CLK); chk("sel itf early", itf_sel, 0);
    @(negedge CLK); chk("sel itf", itf_sel, 1);
    chk("sel cnt", cmd_cnt, 1);
    chk("sel busy", busy, 0);
    chk("sel fifob", qb.size(), 0);
    exp_cnt = 1;

    // single-word command table
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); push_a(vt[i].cmd);
      wait_idle($sformatf("vec%0d", i), 20);
      exp_cnt++;
      chk($sformatf("vec%0d itf", i), itf_sel, vt[i].itf);
      chk($sformatf("vec%0d err_op", i), err_op, vt[i].eop);
      chk($sformatf("vec%0d cnt", i), cmd_cnt, exp_cnt);
      chk($sformatf("vec%0d fifob", i), qb.size(), 0);
    end

    // stray ser_done in IDLE is ignored
    @(negedge CLK); stray_done = 1'b1;
    @(negedge CLK); stray_done = 1'b0;
    repeat (3) @(negedge CLK);
    chk("stray cnt", cmd_cnt, exp_cnt);
    chk("stray busy", busy, 0);
    chk("stray fifob", qb.size(), 0);

    // WRITE of three beats
    @(negedge CLK);
    push_a(32'h2002_0000); push_a(32'h0000_00A1); push_a(32'h0000_00A2); push_a(32'h0000_00A3);
    wait_idle("write", 200);
    exp_cnt++;
    chk("write beats", log_wd.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_wd.size()) begin
        chk($sformatf("write rd%0d", i), log_rd[i], 0);
        chk($sformatf("write wd%0d", i), log_wd[i], 16'h00A1 + 16'(i));
      end
    end
    chk("write cnt", cmd_cnt, exp_cnt);
    chk("write busy", busy, 0);

    // WRITE N=0 stalls in DFETCH until data arrives
    @(negedge CLK); push_a(32'h2000_0000);
    repeat (6) @(negedge CLK);
    chk("stall busy", busy, 1);
    chk("stall req", ser_req, 0);
    push_a(32'h0000_BEEF);
    wait_idle("stall", 50);
    exp_cnt++;
    chk("stall beats", log_wd.size(), 4);
    if (log_wd.size() == 4) chk("stall wd", log_wd[3], 16'hBEEF);
    chk("stall cnt", cmd_cnt, exp_cnt);

    // READ with back-pressure on beat 0
    log_rd.delete(); log_wd.delete();
    rdq.push_back(16'h1234); rdq.push_back(16'h5678);
    @(negedge CLK); FIFOB_prog_full = 1'b1; push_a(32'h3001_0010);
    c = 0;
    while (log_wd.size() < 1 && c < 50) begin @(negedge CLK); c++; end
    chk("read beat0 seen", 32'(c < 50), 1);
    repeat (20) @(negedge CLK);
    chk("read hold fifob", qb.size(), 0);
    chk("read hold req", ser_req, 0);
    FIFOB_prog_full = 1'b0;
    wait_idle("read", 100);
    exp_cnt++;
    chk("read words", qb.size(), 2);
    if (qb.size() == 2) begin
      chk("read w0", qb[0], 32'h3000_1234);
      chk("read w1", qb[1], 32'h3001_5678);
    end
    chk("read beats", log_wd.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < log_wd.size()) begin
        chk($sformatf("read rd%0d", i), log_rd[i], 1);
        chk($sformatf("read addr%0d", i), log_wd[i], 16'h0010);
      end
    end
    chk("read cnt", cmd_cnt, exp_cnt);

    // WAIT_WEI satisfied by status at cycle 10
    qb.delete();
    @(negedge CLK); push_a(32'h4000_0000);
    repeat (10) @(negedge CLK);
    sta_wei = 1'b1;
    c = 0;
    while (qb.size() == 0 && c < 20) begin @(posedge CLK); #1; c++; end
    chk("wei latency", c, 4);
    if (qb.size() > 0) chk("wei word", qb[0], 32'h4000_0000);
    chk("wei err_to", err_to, 0);
    wait_idle("wei", 20);
    exp_cnt++;
    sta_wei = 1'b0;
    repeat (3) @(negedge CLK);

    // WAIT_WEI timeout
    qb.delete();
    push_a(32'h4000_0000);
    c = 0;
    while (qb.size() == 0 && c < 300) begin @(posedge CLK); #1; c++; end
    chk("to latency", c, 104);
    if (qb.size() > 0) chk("to word", qb[0], 32'h4000_0001);
    chk("to err_to", err_to, 1);
    wait_idle("to", 20);
    exp_cnt++;
    chk("to cnt", cmd_cnt, exp_cnt);

    // WAIT_ACT already true on the first WAIT cycle
    sta_act = 1'b1;
    repeat (3) @(negedge CLK);
    qb.delete();
    push_a(32'h5000_0000);
    wait_idle("act", 20);
    exp_cnt++;
    chk("act words", qb.size(), 1);
    if (qb.size() > 0) chk("act word", qb[0], 32'h5000_0000);
    chk("act cnt", cmd_cnt, exp_cnt);
    sta_act = 1'b0;

    // Reset during SREQ of a 4-beat READ
    qb.delete();
    sl_lat = 50;
    @(negedge CLK); push_a(32'h3003_0020);
    c = 0;
    while (!ser_req && c < 20) begin @(posedge CLK); #1; c++; end
    chk("rst mid req seen", 32'(c < 20), 1);
    @(negedge CLK); rst = 1'b1;
    @(posedge CLK); #1;
    chk("rst mid req", ser_req, 0);
    chk("rst mid busy", busy, 0);
    chk("rst mid wen", FIFOB_wen, 0);
    chk("rst mid cnt", cmd_cnt, 0);
    @(negedge CLK); rst = 1'b0; sl_lat = 2;
    chk("rst mid errs", {err_to, err_op, itf_sel}, 0);
    push_a(32'h0000_0000);
    wait_idle("resume", 20);
    chk("resume cnt", cmd_cnt, 1);
    chk("resume fifob", qb.size(), 0);

    chk("ser stable", stab_err, 0);
    chk("wen vs full", wen_full_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
